// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter: WIDTH-bit words go out MSB first with valid/last markers.
// Define PISO_PARITY_EN to append a trailing even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_valid;
    logic             r_last;
`ifdef PISO_PARITY_EN
    logic             r_par;
`endif
    logic             w_accept;

    // A new word may land on the same edge that retires the final bit, giving gapless frames.
    assign load_ready = reset && ((r_state == IDLE) || r_last);
    assign w_accept   = load_valid && load_ready;

    assign sout       = r_sout;
    assign sout_valid = r_valid;
    assign sout_last  = r_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_sout  <= din[WIDTH-1];
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_shift <= {din[WIDTH-2:0], 1'b0};
            r_cnt   <= '0;
`ifdef PISO_PARITY_EN
            r_par   <= ^din;
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    // r_cnt holds the index of the data bit currently on sout.
                    if (r_cnt == CW'(WIDTH-1)) begin
`ifdef PISO_PARITY_EN
                        r_state <= PARITY;
                        r_sout  <= r_par;
                        r_last  <= 1'b1;
`else
                        r_state <= IDLE;
                        r_sout  <= 1'b0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
`endif
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_sout  <= r_shift[WIDTH-1];
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
`ifndef PISO_PARITY_EN
                        r_last  <= (r_cnt == CW'(WIDTH-2));
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    r_state <= IDLE;
                    r_sout  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_sout  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer at WIDTH = 4.
// Expected streams follow PISO_PARITY_EN so the same bench covers both builds.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_last;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] din;
        logic [3:0] expBits;
        logic       expPar;
    } vec_t;

    vec_t vecs[6];

    piso_serializer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic lv, input logic [3:0] d);
        reset      = rst;
        load_valid = lv;
        din        = d;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic eSout, input logic eValid,
                            input logic eLast, input logic eReady);
        checkOutput({tag, " sout"}, sout, eSout);
        checkOutput({tag, " sout_valid"}, sout_valid, eValid);
        checkOutput({tag, " sout_last"}, sout_last, eLast);
        checkOutput({tag, " load_ready"}, load_ready, eReady);
    endtask

    function automatic logic frameBit(input logic [3:0] bits, input logic par, input int c);
        if (c <= 4) return bits[4-c];
        return par;
    endfunction

    logic [9:0] streamExp;
    logic [3:0] busyExp;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{din: 4'b1011, expBits: 4'b1011, expPar: 1'b1};
        vecs[1] = '{din: 4'b0110, expBits: 4'b0110, expPar: 1'b0};
        vecs[2] = '{din: 4'b1100, expBits: 4'b1100, expPar: 1'b0};
        vecs[3] = '{din: 4'b0001, expBits: 4'b0001, expPar: 1'b1};
        vecs[4] = '{din: 4'b1111, expBits: 4'b1111, expPar: 1'b0};
        vecs[5] = '{din: 4'b0000, expBits: 4'b0000, expPar: 1'b0};

`ifdef PISO_PARITY_EN
        streamExp = 10'b10111_01100;
`else
        streamExp = 10'b1011_0110_00;
`endif
        busyExp = 4'b1100;

        // Reset held low with a pending word: everything stays quiet.
        applyStimulus(1'b0, 1'b1, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll($sformatf("reset c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
        checkAll("post-reset", 1'b0, 1'b0, 1'b0, 1'b1);

        // Single frames from the vector table; din is scrambled mid-frame.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b1, 1'b1, vecs[v].din);
            tick();
            applyStimulus(1'b1, 1'b0, ~vecs[v].din);
            for (int c = 1; c <= FLEN; c++) begin
                checkAll($sformatf("vec%0d c%0d", v, c),
                         frameBit(vecs[v].expBits, vecs[v].expPar, c), 1'b1,
                         (c == FLEN), (c == FLEN));
                tick();
            end
            checkAll($sformatf("vec%0d idle", v), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Back-to-back: load_valid held high across two frames.
        applyStimulus(1'b1, 1'b1, 4'b1011);
        tick();
        applyStimulus(1'b1, 1'b1, 4'b0110);
        for (int c = 1; c <= 2 * FLEN; c++) begin
            checkAll($sformatf("b2b c%0d", c), streamExp[10-c], 1'b1,
                     (c == FLEN) || (c == 2 * FLEN), (c == FLEN) || (c == 2 * FLEN));
            if (c == FLEN + 1) applyStimulus(1'b1, 1'b0, 4'b0000);
            tick();
        end
        checkAll("b2b idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Busy ignore: second word offered during the first frame.
        applyStimulus(1'b1, 1'b1, 4'b1100);
        tick();
        applyStimulus(1'b1, 1'b1, 4'b0011);
        for (int c = 1; c <= FLEN; c++) begin
            checkAll($sformatf("busy c%0d", c), frameBit(busyExp, 1'b0, c), 1'b1,
                     (c == FLEN), (c == FLEN));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("busy second sout", sout, 1'b0);
        checkOutput("busy second valid", sout_valid, 1'b1);
        for (int i = 0; i < 20 && sout_valid; i++) tick();
        checkOutput("busy drain valid", sout_valid, 1'b0);

        // Reset mid-frame: frame is abandoned with no last marker.
        applyStimulus(1'b1, 1'b1, 4'b1111);
        tick();
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
        checkAll("midrst c2", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        #1;
        checkOutput("midrst ready low", load_ready, 1'b0);
        tick();
        checkAll("midrst cleared", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < FLEN; i++) begin
            tick();
            checkAll($sformatf("midrst after c%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset and load on the same edge: word is dropped.
        applyStimulus(1'b0, 1'b1, 4'b1111);
        tick();
        checkAll("rst+load", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
        checkAll("rst+load dropped", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
